// File: rtl/aes_dec_pkg.sv
`default_nettype none
// ============================================================================
// Module      : aes_dec_pkg
// Description : Shared types and GF(2^8) helpers for the iterative AES
//               inverse-cipher sequencer: FSM state encoding, block type,
//               round-count function and the inverse round cell functions.
// Revision    : 1.0 - initial release
// ============================================================================
package aes_dec_pkg;

    typedef logic [127:0] block_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ROUND = 2'd1,
        ST_DONE  = 2'd2
    } dec_state_e;

    // Number of cipher rounds for a key of nk 32-bit words.
    function automatic int rounds_f(input int nk);
        return nk + 6;
    endfunction

    // Multiply by x in GF(2^8) modulo the AES polynomial.
    function automatic logic [7:0] xtime(input logic [7:0] x);
        return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = xtime(x);
        end
        return p;
    endfunction

    // Inverse S-box: undo the affine map, then take the multiplicative
    // inverse as x^254 (0 maps to 0 naturally).
    function automatic logic [7:0] inv_sbox(input logic [7:0] x);
        logic [7:0] a;
        logic [7:0] p;
        a = {x[6:0], x[7]} ^ {x[4:0], x[7:5]} ^ {x[1:0], x[7:2]} ^ 8'h05;
        p = gf_mul(a, a);           // a^2
        p = gf_mul(p, a);           // a^3
        p = gf_mul(p, p);           // a^6
        p = gf_mul(p, a);           // a^7
        p = gf_mul(p, p);           // a^14
        p = gf_mul(p, a);           // a^15
        p = gf_mul(p, p);           // a^30
        p = gf_mul(p, a);           // a^31
        p = gf_mul(p, p);           // a^62
        p = gf_mul(p, a);           // a^63
        p = gf_mul(p, p);           // a^126
        p = gf_mul(p, a);           // a^127
        p = gf_mul(p, p);           // a^254
        return p;
    endfunction

    // Row r rotates right by r; byte index = row + 4*column, byte 0 at MSB.
    function automatic block_t inv_shift_rows(input block_t s);
        block_t o;
        o = '0;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                o[127-8*(4*c+r) -: 8] = s[127-8*(4*((c-r+4)%4)+r) -: 8];
            end
        end
        return o;
    endfunction

    function automatic block_t inv_sub_bytes(input block_t s);
        block_t o;
        o = '0;
        for (int i = 0; i < 16; i++) begin
            o[127-8*i -: 8] = inv_sbox(s[127-8*i -: 8]);
        end
        return o;
    endfunction

    function automatic block_t add_round_key(input block_t s, input block_t k);
        return s ^ k;
    endfunction

    function automatic block_t inv_mix_columns(input block_t s);
        block_t     o;
        logic [7:0] a0;
        logic [7:0] a1;
        logic [7:0] a2;
        logic [7:0] a3;
        o = '0;
        for (int c = 0; c < 4; c++) begin
            a0 = s[127-32*c -: 8];
            a1 = s[119-32*c -: 8];
            a2 = s[111-32*c -: 8];
            a3 = s[103-32*c -: 8];
            o[127-32*c -: 8] = gf_mul(a0, 8'h0e) ^ gf_mul(a1, 8'h0b) ^ gf_mul(a2, 8'h0d) ^ gf_mul(a3, 8'h09);
            o[119-32*c -: 8] = gf_mul(a0, 8'h09) ^ gf_mul(a1, 8'h0e) ^ gf_mul(a2, 8'h0b) ^ gf_mul(a3, 8'h0d);
            o[111-32*c -: 8] = gf_mul(a0, 8'h0d) ^ gf_mul(a1, 8'h09) ^ gf_mul(a2, 8'h0e) ^ gf_mul(a3, 8'h0b);
            o[103-32*c -: 8] = gf_mul(a0, 8'h0b) ^ gf_mul(a1, 8'h0d) ^ gf_mul(a2, 8'h09) ^ gf_mul(a3, 8'h0e);
        end
        return o;
    endfunction

endpackage
`default_nettype wire

// File: rtl/aes_dec_iter_if.sv
`default_nettype none
// ============================================================================
// Module      : aes_dec_iter_if
// Description : Block request/response and key-schedule lookup bundle for
//               aes_dec_iter. slave = decryptor view, master = system view.
// Revision    : 1.0 - initial release
// ============================================================================
interface aes_dec_iter_if;
    import aes_dec_pkg::*;

    logic       in_valid;
    logic       in_ready;
    block_t     in_data;
    logic [3:0] key_idx;
    block_t     key_in;
    logic       out_valid;
    logic       out_ready;
    block_t     out_data;
    logic       busy;

    modport master (
        output in_valid, in_data, key_in, out_ready,
        input  in_ready, key_idx, out_valid, out_data, busy
    );

    modport slave (
        input  in_valid, in_data, key_in, out_ready,
        output in_ready, key_idx, out_valid, out_data, busy
    );

endinterface
`default_nettype wire

// File: rtl/inv_round_unit.sv
`default_nettype none
// ============================================================================
// Module      : inv_round_unit
// Description : Combinational AES inverse round: InvShiftRows, InvSubBytes,
//               AddRoundKey, then InvMixColumns unless this is the last round.
// Revision    : 1.0 - initial release
// ============================================================================
module inv_round_unit
    import aes_dec_pkg::*;
(
    input  block_t in,
    input  block_t key,
    input  logic   last,
    output block_t out
);

    block_t w_shifted;
    block_t w_subbed;
    block_t w_keyed;
    block_t w_mixed;

    assign w_shifted = inv_shift_rows(in);
    assign w_subbed  = inv_sub_bytes(w_shifted);
    assign w_keyed   = add_round_key(w_subbed, key);
    assign w_mixed   = inv_mix_columns(w_keyed);

    // The final round skips InvMixColumns.
    assign out = last ? w_keyed : w_mixed;

endmodule
`default_nettype wire

// File: rtl/aes_dec_iter.sv
`default_nettype none
// ============================================================================
// Module      : aes_dec_iter
// Description : Iterative AES inverse cipher. Accepts one ciphertext block,
//               applies the initial AddRoundKey, then reuses one inverse
//               round datapath from round ROUNDS-1 down to 0 and holds the
//               plaintext until the consumer takes it. Round keys come from
//               an external key schedule through a combinational lookup.
//               Optional macro AES_DEC_BLKCNT_EN adds the blk_cnt port, a
//               32-bit wrapping count of completed output handshakes.
// Revision    : 1.0 - initial release
// ============================================================================
module aes_dec_iter
    import aes_dec_pkg::*;
#(
    parameter int NK = 4
) (
    input  logic          clk,
    input  logic          rst,
    aes_dec_iter_if.slave dec
`ifdef AES_DEC_BLKCNT_EN
    ,
    output logic [31:0]   blk_cnt
`endif
);

    localparam int         c_ROUNDS   = rounds_f(NK);
    localparam logic [3:0] c_LAST_IDX = 4'(c_ROUNDS);

    dec_state_e r_fsm;
    dec_state_e w_fsm_nxt;
    block_t     r_state;
    block_t     w_round_out;
    logic [3:0] r_rnd;
    logic       w_accept;
    logic       w_last;

    assign w_last       = (r_rnd == 4'd0);
    assign dec.out_data = r_state;

    inv_round_unit u_round (
        .in   (r_state),
        .key  (dec.key_in),
        .last (w_last),
        .out  (w_round_out)
    );

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) r_fsm <= ST_IDLE;
        else     r_fsm <= w_fsm_nxt;
    end

    // Next-state decode, handshake outputs and key-schedule index.
    always_comb begin
        w_fsm_nxt     = r_fsm;
        w_accept      = 1'b0;
        dec.in_ready  = 1'b0;
        dec.out_valid = 1'b0;
        dec.busy      = 1'b0;
        dec.key_idx   = 4'd0;
        case (r_fsm)
            ST_IDLE: begin
                dec.in_ready = 1'b1;
                dec.key_idx  = c_LAST_IDX;
                if (dec.in_valid) begin
                    w_accept  = 1'b1;
                    w_fsm_nxt = ST_ROUND;
                end
            end
            ST_ROUND: begin
                dec.busy    = 1'b1;
                dec.key_idx = r_rnd;
                if (w_last) w_fsm_nxt = ST_DONE;
            end
            ST_DONE: begin
                dec.out_valid = 1'b1;
                if (dec.out_ready) w_fsm_nxt = ST_IDLE;
            end
            default: w_fsm_nxt = ST_IDLE;
        endcase
    end

    // Block state and round counter: load with whitening key, then one round per cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= '0;
            r_rnd   <= 4'd0;
        end else if (w_accept) begin
            r_state <= add_round_key(dec.in_data, dec.key_in);
            r_rnd   <= c_LAST_IDX - 4'd1;
        end else if (r_fsm == ST_ROUND) begin
            r_state <= w_round_out;
            if (!w_last) r_rnd <= r_rnd - 4'd1;
        end
    end

`ifdef AES_DEC_BLKCNT_EN
    logic [31:0] r_blk_cnt;
    logic        w_out_hs;

    assign w_out_hs = dec.out_valid & dec.out_ready;
    assign blk_cnt  = r_blk_cnt;

    // Completed-block counter, wraps naturally at 32 bits.
    always_ff @(posedge clk) begin
        if (rst)           r_blk_cnt <= 32'd0;
        else if (w_out_hs) r_blk_cnt <= r_blk_cnt + 32'd1;
    end
`endif

endmodule
`default_nettype wire
